// File: rtl/nec_pkg.sv
// Shared types for the NEC command decoder: frame width, queued entry layout,
// decode-stage state encoding and LSB-first byte reversal.
package nec_pkg;

  localparam int NEC_FRAME_BITS = 32;

  typedef struct packed {
    logic        is_repeat;
    logic        extended;
    logic [15:0] address;
    logic [7:0]  command;
  } nec_entry_t;

  typedef enum logic {
    DEC_IDLE   = 1'b0,
    DEC_DECODE = 1'b1
  } dec_state_t;

  function automatic logic [7:0] bit_reverse8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/nec_cmd_fifo.sv
// Generic FIFO with a registered head: a write lands at the edge, head is visible the next cycle.
// A push while full is dropped unless a pop happens in the same cycle.
module nec_cmd_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_next;

  assign empty       = (count == '0);
  assign full        = (count == (AW+1)'(DEPTH));
  assign rd_vld      = !empty;
  assign pop         = rd_vld && rd_rdy;
  assign push        = wr_vld && (!full || pop);
  assign rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;
  // A write landing in the next head slot bypasses the array so the head register is never stale.
  assign head_next   = (push && (wr_ptr == rd_ptr_next)) ? wr_dat : mem[rd_ptr_next];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_dat <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_next;
      if (push || pop) rd_dat <= head_next;
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/nec_command_decoder.sv
// Decodes raw NEC frames, tags held-key repeats and queues commands; strobe at N -> head valid at N+2.
// readyIN pops the head; a full queue drops frames into overflowOUT. NEC_ADDRESS_FILTER_EN enables address filtering.
module nec_command_decoder
  import nec_pkg::*;
#(
  parameter int          CLOCK_SPEED    = 50_000,
  parameter int          HOLD_WINDOW_MS = 120,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [15:0] ADDRESS_MATCH  = 16'h0000
) (
  input  logic                      clkIN,
  input  logic                      nResetIN,
  input  logic                      dataReceivedIN,
  input  logic [NEC_FRAME_BITS-1:0] dataIN,
  input  logic                      clearIN,
  input  logic                      readyIN,
  output logic                      validOUT,
  output logic [7:0]                commandOUT,
  output logic [15:0]               addressOUT,
  output logic                      extendedOUT,
  output logic                      repeatOUT,
  output logic                      overflowOUT,
  output logic [7:0]                errorCountOUT
);

  localparam int PW = (CLOCK_SPEED > 1) ? $clog2(CLOCK_SPEED) : 1;
  localparam int HW = $clog2(HOLD_WINDOW_MS + 1);

  logic [7:0]    b0, b1, b2, b3;
  dec_state_t    dec_state, dec_state_next;
  logic          dec_fire;
  logic          dec_ok, dec_ext;
  logic [15:0]   dec_addr;
  logic [7:0]    dec_cmd;
  logic          addr_pass, accept, err_evt, ovf_evt, pop;
  logic          hold_active, is_rpt;
  logic [PW-1:0] presc;
  logic [HW-1:0] hold_cnt;
  logic [24:0]   key, last_key;
  nec_entry_t    wr_entry, head;
  logic          fifo_full, fifo_empty;

  assign b0 = bit_reverse8(dataIN[31:24]);
  assign b1 = bit_reverse8(dataIN[23:16]);
  assign b2 = bit_reverse8(dataIN[15:8]);
  assign b3 = bit_reverse8(dataIN[7:0]);

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) dec_state <= DEC_IDLE;
    else           dec_state <= dec_state_next;
  end

  always_comb begin
    dec_state_next = dec_state;
    dec_fire       = 1'b0;
    case (dec_state)
      DEC_IDLE:   if (dataReceivedIN) dec_state_next = DEC_DECODE;
      DEC_DECODE: begin
        dec_fire       = 1'b1;
        dec_state_next = dataReceivedIN ? DEC_DECODE : DEC_IDLE;
      end
      default:    dec_state_next = DEC_IDLE;
    endcase
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      dec_ok   <= 1'b0;
      dec_ext  <= 1'b0;
      dec_addr <= '0;
      dec_cmd  <= '0;
    end else if (dataReceivedIN) begin
      dec_ok   <= (b3 == ~b2);
      dec_ext  <= (b1 != ~b0);
      dec_addr <= (b1 == ~b0) ? {8'h00, b0} : {b1, b0};
      dec_cmd  <= b2;
    end
  end

`ifdef NEC_ADDRESS_FILTER_EN
  assign addr_pass = (dec_addr == ADDRESS_MATCH);
`else
  // Every address passes; the OR keeps ADDRESS_MATCH referenced in this build.
  assign addr_pass = 1'b1 | (dec_addr == ADDRESS_MATCH);
`endif

  assign accept      = dec_fire && dec_ok && addr_pass;
  assign err_evt     = dec_fire && !dec_ok;
  assign key         = {dec_ext, dec_addr, dec_cmd};
  assign hold_active = (hold_cnt != '0);
  assign is_rpt      = hold_active && (key == last_key);
  assign wr_entry    = '{is_repeat: is_rpt, extended: dec_ext, address: dec_addr, command: dec_cmd};
  assign pop         = !fifo_empty && readyIN;
  assign ovf_evt     = accept && fifo_full && !pop;

  nec_cmd_fifo #(
    .WIDTH ($bits(nec_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clkIN),
    .rst_n  (nResetIN),
    .wr_vld (accept),
    .wr_dat (wr_entry),
    .rd_rdy (readyIN),
    .rd_vld (validOUT),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign commandOUT  = head.command;
  assign addressOUT  = head.address;
  assign extendedOUT = head.extended;
  assign repeatOUT   = head.is_repeat;

  // Accepted frames restart the hold window even when the queue drops them.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      presc    <= '0;
      hold_cnt <= '0;
      last_key <= '0;
    end else if (accept) begin
      presc    <= '0;
      hold_cnt <= HW'(HOLD_WINDOW_MS);
      last_key <= key;
    end else if (presc == PW'(CLOCK_SPEED - 1)) begin
      presc <= '0;
      if (hold_active) hold_cnt <= hold_cnt - HW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      errorCountOUT <= '0;
      overflowOUT   <= 1'b0;
    end else begin
      if (err_evt)      errorCountOUT <= clearIN ? 8'd1 :
                                         (errorCountOUT == 8'hFF) ? 8'hFF : errorCountOUT + 8'd1;
      else if (clearIN) errorCountOUT <= '0;
      if (ovf_evt)      overflowOUT <= 1'b1;
      else if (clearIN) overflowOUT <= 1'b0;
    end
  end

endmodule
